// File: rtl/pcs_tx_sequencer.sv
// pcs_tx_sequencer: GMII-style frame source for the pcs transmit path.
// Emits preamble, SFD, an incrementing payload and a fixed inter-packet gap.
// Frames launch only while the receive synchronizer reports lock.
// Losing lock mid-frame cuts the frame but still enforces the full gap.
module pcs_tx_sequencer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] seed,
    input  logic       force_err,
    input  logic       code_status,
    output logic       tx_en,
    output logic       tx_er,
    output logic [7:0] txd,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IPG_LAST = 8'(IPG_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_IPG      = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] cnt_r;
    logic [7:0] byte_val_r;
    logic [7:0] len_r;
    logic       err_r;
    logic       frame_ok_r;

    logic       accept_s;
    logic       abort_s;
    logic       last_data_s;
    logic       next_last_s;

    // A request is taken only with lock and a non-empty payload.
    assign accept_s = start && code_status && (frame_len != 8'h00);

    // Lock loss cuts the frame in any transmitting state; the gap ignores it.
    assign abort_s = !code_status &&
                     ((state_r == ST_PREAMBLE) || (state_r == ST_SFD) || (state_r == ST_DATA));

    // Byte position within the payload: current byte is last / next byte is last.
    assign last_data_s = (cnt_r == (len_r - 8'd1));
    assign next_last_s = ((cnt_r + 8'd1) == (len_r - 8'd1));

    // Frame sequencing; every output is loaded with the value for the next cycle.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'h00;
            byte_val_r <= 8'h00;
            len_r      <= 8'h00;
            err_r      <= 1'b0;
            frame_ok_r <= 1'b0;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            txd        <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (abort_s) begin
                state_r    <= ST_IPG;
                cnt_r      <= 8'h00;
                frame_ok_r <= 1'b0;
                tx_en      <= 1'b0;
                tx_er      <= 1'b0;
                txd        <= 8'h00;
                busy       <= 1'b1;
                aborted    <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            state_r    <= ST_PREAMBLE;
                            cnt_r      <= 8'h00;
                            len_r      <= frame_len;
                            byte_val_r <= seed;
                            err_r      <= force_err;
                            frame_ok_r <= 1'b0;
                            tx_en      <= 1'b1;
                            tx_er      <= 1'b0;
                            txd        <= 8'h55;
                            busy       <= 1'b1;
                        end else begin
                            tx_en <= 1'b0;
                            tx_er <= 1'b0;
                            txd   <= 8'h00;
                            busy  <= 1'b0;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (cnt_r == PRE_LAST) begin
                            state_r <= ST_SFD;
                            cnt_r   <= 8'h00;
                            txd     <= 8'hD5;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                            txd   <= 8'h55;
                        end
                    end
                    ST_SFD: begin
                        state_r    <= ST_DATA;
                        cnt_r      <= 8'h00;
                        txd        <= byte_val_r;
                        tx_er      <= err_r && (len_r == 8'd1);
                        byte_val_r <= byte_val_r + 8'd1;
                    end
                    ST_DATA: begin
                        if (last_data_s) begin
                            state_r    <= ST_IPG;
                            cnt_r      <= 8'h00;
                            frame_ok_r <= 1'b1;
                            tx_en      <= 1'b0;
                            tx_er      <= 1'b0;
                            txd        <= 8'h00;
                        end else begin
                            cnt_r      <= cnt_r + 8'd1;
                            txd        <= byte_val_r;
                            tx_er      <= err_r && next_last_s;
                            byte_val_r <= byte_val_r + 8'd1;
                        end
                    end
                    ST_IPG: begin
                        if (cnt_r == IPG_LAST) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 8'h00;
                            busy    <= 1'b0;
                            done    <= frame_ok_r;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'h00;
                        tx_en   <= 1'b0;
                        tx_er   <= 1'b0;
                        txd     <= 8'h00;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Scoreboard bench for pcs_tx_sequencer: the stimulus side predicts, per
// accepted frame, every transmitted byte with its cycle number plus the
// done/aborted event; a negedge monitor pops and compares.
module tb_pcs_tx_sequencer;

    localparam int P   = 7;
    localparam int IPG = 12;

    logic       clk;
    logic       rst_i;
    logic       start_i;
    logic [7:0] len_i;
    logic [7:0] seed_i;
    logic       ferr_i;
    logic       cs_i;
    logic       tx_en;
    logic       tx_er;
    logic [7:0] txd;
    logic       busy;
    logic       done;
    logic       aborted;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       e;
    } byte_t;

    typedef struct {
        int cyc;
        bit kind;   // 0: done, 1: aborted
    } evt_t;

    byte_t dq[$];
    evt_t  eq[$];

    int cyc       = 0;
    int tx_first  = 0;
    int tx_last   = -1;
    int idle_from = 0;
    bit mon_on    = 1'b0;
    int n_checks  = 0;
    int n_fail    = 0;

    pcs_tx_sequencer #(.PREAMBLE_LEN(P), .IPG_LEN(IPG)) dut (
        .clk        (clk),
        .RESET      (rst_i),
        .start      (start_i),
        .frame_len  (len_i),
        .seed       (seed_i),
        .force_err  (ferr_i),
        .code_status(cs_i),
        .tx_en      (tx_en),
        .tx_er      (tx_er),
        .txd        (txd),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drop every prediction from cycle c onwards.
    task automatic flush(input int c);
        while (dq.size() > 0 && dq[dq.size()-1].cyc >= c) void'(dq.pop_back());
        while (eq.size() > 0 && eq[eq.size()-1].cyc >= c) void'(eq.pop_back());
    endtask

    // Reference model applied at edge e with the inputs the DUT just sampled.
    // Cycle c is the interval following edge c.
    task automatic model_edge(input int e);
        byte_t b;
        evt_t  v;
        if (rst_i) begin
            flush(e);
            tx_first  = e;
            tx_last   = e - 1;
            idle_from = e;
            mon_on    = 1'b1;
        end else if ((e - 1) >= tx_first && (e - 1) <= tx_last && !cs_i) begin
            flush(e);
            v.cyc = e; v.kind = 1'b1; eq.push_back(v);
            tx_last   = e - 1;
            idle_from = e + IPG;
        end else if ((e - 1) >= idle_from && start_i && cs_i && len_i != 8'd0) begin
            for (int k = 0; k < P; k++) begin
                b.cyc = e + k; b.d = 8'h55; b.e = 1'b0; dq.push_back(b);
            end
            b.cyc = e + P; b.d = 8'hD5; b.e = 1'b0; dq.push_back(b);
            for (int i = 0; i < int'(len_i); i++) begin
                b.cyc = e + P + 1 + i;
                b.d   = 8'((int'(seed_i) + i) % 256);
                b.e   = ferr_i && (i == int'(len_i) - 1);
                dq.push_back(b);
            end
            tx_first  = e;
            tx_last   = e + P + int'(len_i);
            idle_from = tx_last + IPG + 1;
            v.cyc = idle_from; v.kind = 1'b0; eq.push_back(v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        #1;
    endtask

    // Monitor: compare DUT outputs against the predictions for this cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("byte_missing_at", dq[0].cyc, cyc);
                void'(dq.pop_front());
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                chk("tx_en", tx_en, 1);
                chk("txd", txd, dq[0].d);
                chk("tx_er", tx_er, dq[0].e);
                void'(dq.pop_front());
            end else begin
                chk("tx_en_idle", tx_en, 0);
                chk("txd_idle", txd, 0);
                chk("tx_er_idle", tx_er, 0);
            end
            chk("busy", busy, (cyc >= tx_first && cyc < idle_from) ? 1 : 0);
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                chk("event_missing_at", eq[0].cyc, cyc);
                void'(eq.pop_front());
            end
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                chk("done", done, eq[0].kind ? 0 : 1);
                chk("aborted", aborted, eq[0].kind ? 1 : 0);
                void'(eq.pop_front());
            end else begin
                chk("done_idle", done, 0);
                chk("aborted_idle", aborted, 0);
            end
        end
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = 8'd0; seed_i = 8'd0; ferr_i = 1'b0; cs_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        step();

        // Basic frame
        start_i = 1'b1; len_i = 8'd4; seed_i = 8'h10; step();
        start_i = 1'b0; repeat (30) step();

        // Wrap and error on the last byte
        start_i = 1'b1; len_i = 8'd3; seed_i = 8'hFE; ferr_i = 1'b1; step();
        start_i = 1'b0; ferr_i = 1'b0; repeat (30) step();

        // Minimum frame with error
        start_i = 1'b1; len_i = 8'd1; seed_i = 8'h77; ferr_i = 1'b1; step();
        start_i = 1'b0; ferr_i = 1'b0; repeat (25) step();

        // Gating: no lock, then zero length
        cs_i = 1'b0; start_i = 1'b1; len_i = 8'd5; repeat (3) step();
        start_i = 1'b0; cs_i = 1'b1; step();
        start_i = 1'b1; len_i = 8'd0; repeat (3) step();
        start_i = 1'b0; step();

        // Start held high: back-to-back frames at minimum spacing
        start_i = 1'b1; len_i = 8'd2; seed_i = 8'h30; repeat (40) step();
        start_i = 1'b0; repeat (30) step();

        // Abort during the 2nd payload byte
        start_i = 1'b1; len_i = 8'd10; seed_i = 8'h40; step();
        start_i = 1'b0; repeat (P + 2) step();
        cs_i = 1'b0; step();
        cs_i = 1'b1; repeat (30) step();

        // Reset during SFD, then a clean frame
        start_i = 1'b1; len_i = 8'd6; seed_i = 8'h80; step();
        start_i = 1'b0; repeat (P) step();
        rst_i = 1'b1; step();
        rst_i = 1'b0; step();
        start_i = 1'b1; len_i = 8'd3; seed_i = 8'h01; step();
        start_i = 1'b0; repeat (30) step();

        // Randomized traffic with lock drops and rare resets
        for (int n = 0; n < 3000; n++) begin
            start_i = ($urandom_range(0, 7) == 0);
            len_i   = 8'($urandom_range(0, 24));
            seed_i  = 8'($urandom_range(0, 255));
            ferr_i  = 1'($urandom_range(0, 1));
            if (cs_i) cs_i = ($urandom_range(0, 59) != 0);
            else      cs_i = ($urandom_range(0, 2) == 0);
            rst_i   = ($urandom_range(0, 499) == 0);
            step();
        end

        // Drain
        rst_i = 1'b0; start_i = 1'b0; cs_i = 1'b1;
        repeat (60) step();
        chk("data_queue_empty", dq.size(), 0);
        chk("event_queue_empty", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_tx_sequencer.md
# pcs_tx_sequencer

Frame sequencer that drives the transmit side of the `pcs` block (`tx_en`, `tx_er`, `txd`). On request, it emits a complete GMII-style frame:

- preamble
- start-of-frame delimiter (SFD)
- a deterministic incrementing payload
- a mandatory inter-packet gap (IPG)

Transmission is gated by the receive synchronizer's `code_status`, so frames are only launched once the link is synchronized. The block sits above `pcs` and is the stimulus and traffic source for loopback bring-up of the transmit code-group, synchronizer and receive path.

## Interface

Parameters:
- `PREAMBLE_LEN`, default 7: number of 0x55 preamble bytes; legal range 1..15.
- `IPG_LEN`, default 12: idle cycles after each frame; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request, sampled every edge.
- `frame_len`  in  8  payload byte count; captured on accepted `start`; 0 is illegal.
- `seed`  in  8  first payload byte; captured on accepted `start`.
- `force_err`  in  1  captured on accepted `start`; when set, `tx_er` marks the last payload byte.
- `code_status`  in  1  synchronizer lock indication from `pcs`.
- `tx_en`  out  1  to `pcs.tx_en`.
- `tx_er`  out  1  to `pcs.tx_er`.
- `txd`  out  8  to `pcs.txd`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal frame completion.
- `aborted`  out  1  one-cycle pulse when a frame is cut by loss of `code_status`.

## Operation

- All outputs are registered.
- States: IDLE, PREAMBLE, SFD, DATA, IPG. Counters are 8-bit: `cnt` counts bytes within a state; `byte_val` holds the next payload byte.

Start acceptance:
- `start` is accepted only when all of the following hold: state is IDLE, `code_status`=1, and `frame_len`≠0.
- Otherwise `start` is ignored; there is no queuing.

State behavior:
- **IDLE:** `tx_en`=0, `tx_er`=0, `txd`=0x00. On an accepted `start`:
  - latch `frame_len`, `seed` and `force_err`
  - go to PREAMBLE.
- **PREAMBLE:** `tx_en`=1, `txd`=0x55 for exactly `PREAMBLE_LEN` cycles, then go to SFD.
- **SFD:** `tx_en`=1, `txd`=0xD5 for one cycle, then go to DATA.
- **DATA:** `tx_en`=1, `txd`=`byte_val` for exactly the latched `frame_len` cycles.
  - `byte_val` starts at `seed` and increments by 1 each cycle, modulo 256 (0xFF→0x00).
  - `tx_er`=1 only on the final DATA cycle, and only if the latched `force_err`=1.
  - After the final DATA cycle, go to IPG.
- **IPG:** `tx_en`=0, `tx_er`=0, `txd`=0x00 for exactly `IPG_LEN` cycles, then go to IDLE.
  - `done` pulses only if the frame completed normally.

Abort:
- If `code_status`=0 is sampled in PREAMBLE, SFD or DATA, the next state is IPG.
- On that abort:
  - `tx_en` and `tx_er` drop on the following cycle
  - `aborted` pulses for that one cycle
  - the full `IPG_LEN` gap is still enforced
  - `done` is not asserted for that frame.
- `code_status` is ignored during IPG.

Other rules:
- `start` is ignored whenever `busy`=1.
- `RESET`=1 at any edge, including mid-frame:
  - state becomes IDLE and all counters are cleared
  - outputs take reset values at the next cycle
  - any in-progress frame is dropped with no `done` or `aborted` pulse.

## Timing

- Reset values: `tx_en`=0, `tx_er`=0, `txd`=0x00, `busy`=0, `done`=0, `aborted`=0.

Frame latency:
- `start` accepted at edge N: the first 0x55 is on `txd` with `tx_en`=1 during cycle N+1.
- `busy` also rises at N+1.

Frame length:
- `tx_en` stays high for exactly `PREAMBLE_LEN` + 1 + `frame_len` consecutive cycles.
- `txd` and `tx_en`/`tx_er` change together on the same edge.

End of frame:
- `done` rises in the first IDLE cycle after IPG, the same cycle `busy` falls.
- A `start` sampled at the edge ending that cycle is accepted, giving a minimum frame-to-frame spacing of exactly `IPG_LEN` + 1 idle cycles.

Abort timing:
- `code_status` low sampled at edge M: `tx_en`=0 and `aborted`=1 in cycle M+1.
- IDLE is re-entered at cycle M+1+`IPG_LEN`.

Minimum frame:
- `frame_len`=1 produces a single DATA byte.
- If `force_err`=1, `tx_er` is set on that byte.

## Test plan

- **Basic frame:** defaults, `code_status`=1, `start` with `frame_len`=4, `seed`=0x10.
  - `txd` = 7×0x55, 0xD5, 0x10, 0x11, 0x12, 0x13 with `tx_en` high for 12 cycles.
  - Then 12 cycles of `tx_en`=0, then `done` for 1 cycle.
  - `tx_er` stays 0.
- **Wrap and error:** `seed`=0xFE, `frame_len`=3, `force_err`=1.
  - Payload is 0xFE, 0xFF, 0x00.
  - `tx_er`=1 only on the 0x00 byte.
- **Gating:**
  - `start` with `code_status`=0 → no activity, `busy` stays 0.
  - `start` with `frame_len`=0 → ignored.
  - `start` held high while `busy` → only one frame is sent.
  - The next frame's first 0x55 appears exactly 13 cycles after the last DATA byte.
- **Abort:** drop `code_status` during the 2nd DATA byte of a `frame_len`=10 frame.
  - `tx_en` falls the next cycle and `aborted` pulses once.
  - 12 idle cycles follow; no `done`.
- **Reset mid-frame:** assert `RESET` for 1 cycle during SFD.
  - The next cycle has all outputs 0 and state IDLE.
  - A new `start` then produces a clean frame starting with 0x55.
